// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to transmitter and receiver,
// default frame geometry and the line idle level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_NBITS   = 8;
  localparam int   UART_OS_RATE = 16;
  localparam logic LINE_IDLE    = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divides clk by CLK_DIV, with a synchronous clear so
// a frame can be phase-aligned to its own start.
module uart_baud_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic os_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign os_tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input, 16x-oversampled bit timing
// and a one-cycle tx_done pulse at the end of each stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int OS_RATE = UART_OS_RATE,
  parameter int NBITS   = UART_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [NBITS-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int            OW       = $clog2(OS_RATE);
  localparam int            BW       = $clog2(NBITS) + 1;
  localparam logic [OW-1:0] OS_LAST  = OW'(OS_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  uart_state_e      state;
  logic [NBITS-1:0] shift_reg;
  logic [NBITS-1:0] shift_next;
  logic [OW-1:0]    os_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             os_tick;
  logic             bit_end;

  assign tx_ready   = ~tx_busy;
  assign accept     = (state == IDLE) && tx_valid && tx_ready;
  assign bit_end    = os_tick && (os_cnt == OS_LAST);
  assign shift_next = shift_reg >> 1;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .os_tick(os_tick)
  );

  // Outputs are set on the same edge as the state change so tx, tx_busy and
  // tx_done line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      tx        <= LINE_IDLE;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE && os_tick) begin
        os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            tx        <= ~LINE_IDLE;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              tx    <= LINE_IDLE;
              state <= STOP;
            end else begin
              tx <= shift_next[0];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (CLK_DIV=1 and CLK_DIV=3) checked cycle by cycle
// against a frame-level model of the expected line waveform.
module tb_uart_tx;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      tx_valid;
  logic [1:0][7:0] tx_data;
  logic [1:0]      tx_ready;
  logic [1:0]      tx;
  logic [1:0]      tx_busy;
  logic [1:0]      tx_done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIV(1), .OS_RATE(16), .NBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  uart_tx #(.CLK_DIV(3), .OS_RATE(16), .NBITS(8)) dut_div3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  function automatic int bper(input int u);
    return (u == 0) ? 16 : 48;
  endfunction

  // Line level n cycles after the acceptance cycle for a frame carrying d.
  function automatic logic exp_tx(input logic [7:0] d, input int n, input int b);
    int k;
    if (n < 1 || n > 10 * b) return 1'b1;
    k = (n - 1) / b;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered at the falling edge of the acceptance cycle with tx_valid already high.
  // hold keeps tx_valid asserted with nd on tx_data for the whole frame.
  task automatic frame(input int u, input logic [7:0] d, input bit hold,
                       input logic [7:0] nd, input int last_n);
    int b;
    logic [7:0] rx;
    b  = bper(u);
    rx = '0;
    chk("accept_ready", tx_ready[u], 1'b1);
    @(posedge clk); #1;
    tx_valid[u] = hold;
    tx_data[u]  = hold ? nd : 8'($urandom);
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      chk("tx_line", tx[u], exp_tx(d, n, b));
      chk("tx_busy", tx_busy[u], n <= 10 * b);
      chk("tx_done", tx_done[u], n == 10 * b + 1);
      chk("tx_ready", tx_ready[u], n > 10 * b);
      if (n > b && n <= 9 * b && ((n - 1) % b) == b / 2) rx[(n - 1) / b - 1] = tx[u];
      if (n < last_n) begin
        @(posedge clk); #1;
      end
    end
    if (last_n == 10 * b + 1) chk8("rx_byte", rx, d);
  endtask

  task automatic present(input int u, input logic [7:0] d);
    @(posedge clk); #1;
    tx_valid[u] = 1'b1;
    tx_data[u]  = d;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r1, r2;
    tx_valid = '0;
    tx_data  = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("rst_tx", tx[0], 1'b1);
      chk("rst_ready", tx_ready[0], 1'b1);
      chk("rst_busy", tx_busy[0], 1'b0);
      chk("rst_done", tx_done[0], 1'b0);
      chk("rst_tx_div3", tx[1], 1'b1);
    end

    present(0, 8'hA5);
    frame(0, 8'hA5, 1'b0, 8'h00, 161);

    present(0, 8'h00);
    frame(0, 8'h00, 1'b1, 8'hFF, 161);
    frame(0, 8'hFF, 1'b0, 8'h00, 161);

    present(0, 8'h3C);
    frame(0, 8'h3C, 1'b1, 8'hFF, 161);
    frame(0, 8'hFF, 1'b0, 8'h00, 161);

    // Reset pulse in the middle of data bit 3.
    present(0, 8'hC3);
    frame(0, 8'hC3, 1'b0, 8'h00, 1 + 4 * 16 + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx[0], 1'b1);
    chk("midrst_busy", tx_busy[0], 1'b0);
    chk("midrst_done", tx_done[0], 1'b0);
    chk("midrst_ready", tx_ready[0], 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      chk("postrst_tx", tx[0], 1'b1);
      chk("postrst_done", tx_done[0], 1'b0);
    end
    present(0, 8'h55);
    frame(0, 8'h55, 1'b0, 8'h00, 161);

    for (int i = 0; i < 4; i++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      present(0, r1);
      if (i % 2 == 0) begin
        frame(0, r1, 1'b0, 8'h00, 161);
      end else begin
        frame(0, r1, 1'b1, r2, 161);
        frame(0, r2, 1'b0, 8'h00, 161);
      end
    end

    present(1, 8'h81);
    frame(1, 8'h81, 1'b0, 8'h00, 481);
    r1 = 8'($urandom);
    present(1, r1);
    frame(1, r1, 1'b0, 8'h00, 481);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit) at a 16x-oversampled bit period. It is the sending end of the link whose receiver counts 16 oversample ticks per data bit. It accepts one byte per valid/ready handshake, drives the serial line, and pulses `tx_done` when the stop bit completes. It sits between the byte-level producer and the pad.

## Interface
- `CLK_DIV`, default 1: `clk` cycles per oversample tick. Must be ≥1.
- `OS_RATE`, default 16: oversample ticks per bit. Must be ≥2.
- `NBITS`, default 8: data bits per frame.
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_data`  in  NBITS  byte to send. Sampled only on acceptance.
- `tx_ready`  out  1  block can accept a byte. High only in IDLE.
- `tx`  out  1  serial line. Idle and stop level = 1. Registered.
- `tx_busy`  out  1  frame in progress (START/DATA/STOP).
- `tx_done`  out  1  one-cycle pulse when a frame finishes.

## Operation
- FSM states are IDLE, START, DATA and STOP.
- **IDLE:** `tx`=1. If `tx_valid && tx_ready`, load `tx_data` into the shift register, clear the counters, and go to START.
- **START:** `tx`=0 for one bit period, then go to DATA.
- **DATA:** `tx` = shift_reg[0]. At the end of each bit period, shift right and increment the bit counter. After the bit with index NBITS-1, go to STOP.
- **STOP:** `tx`=1 for one bit period, then go to IDLE and assert `tx_done`.
- One bit period B = OS_RATE × CLK_DIV clk cycles.
  - Tick divider: counts 0..CLK_DIV-1 and emits a tick at the terminal count.
  - Oversample counter: counts 0..OS_RATE-1 on ticks. The bit ends on the tick where it reaches OS_RATE-1.
  - Both counters clear on acceptance, so every frame is phase-aligned to its own acceptance.
- Handshake and data capture:
  - `tx_valid` while busy is ignored (`tx_ready`=0); the producer must hold it until acceptance.
  - Changes to `tx_data` after acceptance have no effect on the frame in flight.
- Bit counter width is clog2(NBITS)+1. The oversample counter is wide enough for OS_RATE-1. No wrap-around beyond the terminal counts.
- **Reset values:**
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - State IDLE; counters and shift register 0.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronously). The frame is dropped and no `tx_done` is produced.

## Timing
- Acceptance edge is cycle 0. `tx` falls at cycle 1.
- Start bit occupies cycles 1..B. Data bit i occupies cycles 1+(i+1)B .. (i+2)B. Stop bit occupies cycles 1+9B .. 10B.
- At cycle 1+10B: state is IDLE, `tx_done`=1 for exactly this cycle, and `tx_ready`=1.
  - A byte accepted at 1+10B starts its start bit at 2+10B.
  - The minimum idle-high gap between frames is therefore 1 cycle beyond the stop bit.
- `tx_busy` is high in cycles 1..10B. `tx_ready` = !`tx_busy`.
- Accept-to-done latency is 1+10B cycles. With defaults this is 161.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE=0, START=1, DATA=2, STOP=3), common with the receiver;
  - default `NBITS` and `OS_RATE`;
  - the line idle level constant.
- Sub-module `uart_baud_tick` is the CLK_DIV divider with synchronous clear, producing a one-cycle `os_tick`. It is reusable by the receiver.

## Test plan
- **Reset:** assert `rst_n`=0, release, and hold `tx_valid`=0 for 50 cycles → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout.
- **Single frame:** defaults, send 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles starting at cycle 1. `tx_done` pulses at cycle 161 only.
- **Back-to-back:** send 0x00 then 0xFF with `tx_valid` held → second frame accepted at cycle 161, its start bit begins at 162. Exactly two `tx_done` pulses, 161 cycles apart.
- **Ignored inputs:** accept 0x3C, then drive `tx_data`=0xFF with `tx_valid`=1 during the frame → line still carries 0x3C. 0xFF is accepted only after `tx_done`.
- **Reset mid-frame:** pulse `rst_n` low during data bit 3 → `tx`=1 immediately and no `tx_done`. A following send of 0x55 completes with correct timing.
- **Non-default divider:** `CLK_DIV`=3, send 0x81 → each bit lasts 48 cycles and `tx_done` arrives at cycle 481. Loopback into the 16x receiver recovers 0x81.
